// File: rtl/multi_tile_boot_loader.sv
// Boot controller: holds tile CPUs in reset while streaming a firmware image from SPI flash
// (mode 0, READ 0x03) into per-tile instruction SRAMs, with optional trailing checksum byte.
module multi_tile_boot_loader #(
    parameter int          N_TILES     = 9,
    parameter int          ADDR_W      = 8,
    parameter int          DATA_W      = 8,
    parameter int          CLK_DIV     = 1,
    parameter logic [23:0] FLASH_BASE  = 24'h000000,
    parameter int          CHECKSUM_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               flash_cs_n,
    output logic               flash_clk,
    output logic               flash_mosi,
    input  logic               flash_miso,
    output logic [N_TILES-1:0] sram_tile_sel,
    output logic [ADDR_W-1:0]  sram_waddr,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic               sram_wen,
    output logic               cpu_reset_n,
    output logic               boot_done,
    output logic               boot_err
);

    localparam int          DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int          BIT_MAX = (DATA_W > 32) ? DATA_W : 32;
    localparam int          BC_W    = $clog2(BIT_MAX + 1);
    localparam int          N_BYTES = DATA_W / 8;
    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_READ,
        S_WRITE,
        S_CHECK,
        S_CMP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [BC_W-1:0]    bit_cnt;
    logic [31:0]        cmd_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [N_TILES-1:0] tile_oh;
    logic [7:0]         sum;
    logic [7:0]         sum_nxt;

    logic shifting;
    logic div_end;
    logic bit_last;
    logic fall_edge;
    logic word_done;
    logic last_word;

    always_comb begin
        shifting  = (state == S_CMD) || (state == S_READ) || (state == S_CHECK);
        div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
        bit_last  = 1'b0;
        case (state)
            S_CMD:   bit_last = (bit_cnt == BC_W'(31));
            S_READ:  bit_last = (bit_cnt == BC_W'(DATA_W - 1));
            S_CHECK: bit_last = (bit_cnt == BC_W'(7));
            default: bit_last = 1'b0;
        endcase
        fall_edge = shifting && div_end && flash_clk;
        word_done = fall_edge && bit_last;
        last_word = (addr_cnt == '1) && tile_oh[N_TILES-1];
    end

    // Checksum accumulates every byte of the word currently presented during WRITE.
    always_comb begin
        sum_nxt = sum;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            sum_nxt = sum_nxt + sram_wdata[i*8 +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_CMD;
            S_CMD:   if (word_done) state_nxt = S_READ;
            S_READ:  if (word_done) state_nxt = S_WRITE;
            S_WRITE: begin
                if (!last_word)            state_nxt = S_READ;
                else if (CHECKSUM_EN != 0) state_nxt = S_CHECK;
                else                       state_nxt = S_DONE;
            end
            S_CHECK: if (word_done) state_nxt = S_CMP;
            S_CMP:   state_nxt = (rx_sr[7:0] == sum) ? S_DONE : S_ERROR;
            S_DONE:  state_nxt = S_DONE;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cs_n    <= 1'b1;
            flash_clk     <= 1'b0;
            flash_mosi    <= 1'b0;
            sram_tile_sel <= '0;
            sram_waddr    <= '0;
            sram_wdata    <= '0;
            sram_wen      <= 1'b1;
            cpu_reset_n   <= 1'b0;
            boot_done     <= 1'b0;
            boot_err      <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            cmd_sr        <= '0;
            rx_sr         <= '0;
            addr_cnt      <= '0;
            tile_oh       <= N_TILES'(1);
            sum           <= '0;
        end else begin
            // SCK generator: low phase then high phase of CLK_DIV cycles per bit.
            if (shifting) begin
                if (div_end) begin
                    div_cnt <= '0;
                    if (!flash_clk) begin
                        flash_clk <= 1'b1;
                        if (state != S_CMD) rx_sr <= {rx_sr[DATA_W-2:0], flash_miso};
                    end else begin
                        flash_clk <= 1'b0;
                        bit_cnt   <= bit_last ? '0 : bit_cnt + BC_W'(1);
                        if (state == S_CMD) begin
                            flash_mosi <= bit_last ? 1'b0 : cmd_sr[31];
                            cmd_sr     <= cmd_sr << 1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    flash_cs_n <= 1'b0;
                    flash_mosi <= CMD_WORD[31];
                    cmd_sr     <= CMD_WORD << 1;
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                end
                S_READ: begin
                    if (word_done) begin
                        sram_wen      <= 1'b0;
                        sram_wdata    <= rx_sr;
                        sram_tile_sel <= tile_oh;
                        sram_waddr    <= addr_cnt;
                    end
                end
                S_WRITE: begin
                    sram_wen      <= 1'b1;
                    sram_tile_sel <= '0;
                    sram_waddr    <= '0;
                    sum           <= sum_nxt;
                    if (addr_cnt == '1) begin
                        addr_cnt <= '0;
                        tile_oh  <= tile_oh << 1;
                    end else begin
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end
                    if (last_word && (CHECKSUM_EN == 0)) begin
                        flash_cs_n  <= 1'b1;
                        flash_mosi  <= 1'b0;
                        cpu_reset_n <= 1'b1;
                        boot_done   <= 1'b1;
                    end
                end
                S_CMP: begin
                    flash_cs_n <= 1'b1;
                    flash_mosi <= 1'b0;
                    if (rx_sr[7:0] == sum) begin
                        cpu_reset_n <= 1'b1;
                        boot_done   <= 1'b1;
                    end else begin
                        boot_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_tile_boot_loader.sv
// Self-checking bench: behavioural SPI flash, SRAM write recorder, and expected values
// derived from the flash image layout and the load-latency formula.
module tb_multi_tile_boot_loader;

    localparam int          NT    = 2;
    localparam int          AW    = 2;
    localparam int          DW    = 16;
    localparam int          D     = 2;
    localparam int          CE    = 1;
    localparam logic [23:0] BASE  = 24'h012345;
    localparam int          DEPTH = 1 << AW;
    localparam int          W     = NT * DEPTH;
    localparam int          BPW   = DW / 8;
    localparam int          NB    = W * BPW;
    localparam int          LAT   = 1 + 64*D + W*(2*D*DW + 1) + CE*(16*D + 1);
    localparam int          RW    = NT + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flash_cs_n, flash_clk, flash_mosi;
    logic          flash_miso = 1'b0;
    logic [NT-1:0] sram_tile_sel;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;
    logic          sram_wen, cpu_reset_n, boot_done, boot_err;

    multi_tile_boot_loader #(
        .N_TILES(NT), .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(D),
        .FLASH_BASE(BASE), .CHECKSUM_EN(CE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .flash_cs_n(flash_cs_n), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
        .flash_miso(flash_miso),
        .sram_tile_sel(sram_tile_sel), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .sram_wen(sram_wen), .cpu_reset_n(cpu_reset_n), .boot_done(boot_done),
        .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    logic [7:0] img [0:NB];

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [23:0] off;
        off = a - BASE;
        if (a >= BASE && int'(off) <= NB) return img[int'(off)];
        return 8'hFF;
    endfunction

    // Flash model: command captured on rising SCK, data driven on falling SCK.
    int          fbits = 0;
    int          cmd_count = 0;
    logic [31:0] fcmd = '0;
    logic [31:0] last_cmd = '0;
    always @(posedge flash_clk or negedge flash_clk or posedge flash_cs_n) begin
        if (flash_cs_n) begin
            fbits = 0;
            flash_miso = 1'b0;
        end else if (flash_clk) begin
            if (fbits < 32) fcmd = {fcmd[30:0], flash_mosi};
            fbits++;
            if (fbits == 32) begin
                cmd_count++;
                last_cmd = fcmd;
            end
        end else if (fbits >= 32) begin
            int n;
            logic [7:0] b;
            n = fbits - 32;
            b = fbyte(fcmd[23:0] + 24'(n / 8));
            flash_miso = b[7 - (n % 8)];
        end
    end

    // Bus monitor sampled on the inactive clock edge.
    logic [RW-1:0] wq [$];
    int   wen_viol = 0, sel_viol = 0, ph_viol = 0, hi_run = 0;
    logic prev_wen = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wen = 1'b1;
            prev_sck = 1'b0;
            prev_mosi = 1'b0;
            hi_run = 0;
        end else begin
            if (!sram_wen) begin
                wq.push_back({sram_tile_sel, sram_waddr, sram_wdata});
                if (!prev_wen) wen_viol++;
            end else if (sram_tile_sel != '0 || sram_waddr != '0) begin
                sel_viol++;
            end
            if (flash_clk) begin
                hi_run++;
                if (prev_sck && flash_mosi !== prev_mosi) ph_viol++;
            end else begin
                if (prev_sck) begin
                    if (hi_run != D) ph_viol++;
                    hi_run = 0;
                end else if (flash_mosi !== prev_mosi) begin
                    ph_viol++;
                end
            end
            prev_wen = sram_wen;
            prev_sck = flash_clk;
            prev_mosi = flash_mosi;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic make_image(input bit good);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < NB; i++) begin
            img[i] = 8'($urandom);
            s = s + img[i];
        end
        img[NB] = good ? s : s + 8'($urandom_range(1, 255));
    endtask

    task automatic run_load(output int cyc, input int limit);
        cyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (cyc < limit && !(boot_done || boot_err)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_writes(input int base, input string tag);
        logic [RW-1:0] e;
        logic [63:0]   obs;
        logic [NT-1:0] ts;
        logic [DW-1:0] word;
        chk({tag, "_count"}, 64'(wq.size() - base), 64'(W));
        for (int k = 0; k < W; k++) begin
            ts = NT'(1) << (k / DEPTH);
            word = '0;
            for (int b = 0; b < BPW; b++) word = {word[DW-9:0], img[k*BPW + b]};
            e = {ts, AW'(k % DEPTH), word};
            obs = 'x;
            if (base + k < wq.size()) obs = 64'(wq[base + k]);
            chk($sformatf("%s_w%0d", tag, k), obs, 64'(e));
        end
    endtask

    int cyc;
    int base;
    int cmds;

    initial begin
        make_image(1'b1);
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(flash_cs_n), 64'(1));
        chk("rst_sck", 64'(flash_clk), 64'(0));
        chk("rst_mosi", 64'(flash_mosi), 64'(0));
        chk("rst_wen", 64'(sram_wen), 64'(1));
        chk("rst_waddr", 64'(sram_waddr), 64'(0));
        chk("rst_wdata", 64'(sram_wdata), 64'(0));
        chk("rst_tile", 64'(sram_tile_sel), 64'(0));
        chk("rst_cpu", 64'(cpu_reset_n), 64'(0));
        chk("rst_done", 64'(boot_done), 64'(0));
        chk("rst_err", 64'(boot_err), 64'(0));

        // Clean load
        base = wq.size();
        run_load(cyc, 5000);
        chk("good_latency", 64'(cyc), 64'(LAT));
        chk("good_cmd", 64'(last_cmd), 64'({8'h03, BASE}));
        check_writes(base, "good");
        chk("good_cpu", 64'(cpu_reset_n), 64'(1));
        chk("good_err", 64'(boot_err), 64'(0));
        chk("good_cs_n", 64'(flash_cs_n), 64'(1));
        repeat (50) @(negedge clk);
        chk("good_sticky", 64'({boot_done, cpu_reset_n, boot_err, sram_wen}), 64'(4'b1101));

        // Bad checksum
        @(negedge clk);
        rst_n = 1'b0;
        make_image(1'b0);
        repeat (2) @(negedge clk);
        chk("bad_rst_done", 64'(boot_done), 64'(0));
        base = wq.size();
        run_load(cyc, 5000);
        chk("bad_latency", 64'(cyc), 64'(LAT));
        check_writes(base, "bad");
        chk("bad_err", 64'(boot_err), 64'(1));
        chk("bad_done", 64'(boot_done), 64'(0));
        repeat (1000) @(negedge clk);
        chk("bad_cpu_held", 64'({cpu_reset_n, boot_err, flash_cs_n}), 64'(3'b011));
        chk("bad_no_extra", 64'(wq.size() - base), 64'(W));

        // Reset asserted mid-READ of tile 1
        @(negedge clk);
        rst_n = 1'b0;
        make_image(1'b1);
        repeat (2) @(negedge clk);
        base = wq.size();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 5000 && wq.size() < base + DEPTH + 1) begin
            @(posedge clk);
            cyc++;
        end
        chk("mid_reached_tile1", 64'(wq.size() - base >= DEPTH + 1), 64'(1));
        repeat (10) @(posedge clk);
        #3;
        chk("mid_cs_low_before", 64'(flash_cs_n), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_async_rst", 64'({flash_cs_n, flash_clk, flash_mosi, sram_wen, cpu_reset_n}),
            64'(5'b10010));
        chk("mid_async_data", 64'({sram_tile_sel, sram_waddr, sram_wdata}), 64'(0));
        repeat (2) @(negedge clk);
        cmds = cmd_count;
        base = wq.size();
        run_load(cyc, 5000);
        chk("mid_latency", 64'(cyc), 64'(LAT));
        chk("mid_cmd_resent", 64'(cmd_count - cmds), 64'(1));
        chk("mid_cmd", 64'(last_cmd), 64'({8'h03, BASE}));
        check_writes(base, "mid");
        chk("mid_done", 64'({boot_done, cpu_reset_n}), 64'(2'b11));

        chk("wen_single_cycle", 64'(wen_viol), 64'(0));
        chk("sel_idle_zero", 64'(sel_viol), 64'(0));
        chk("sck_phase", 64'(ph_viol), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
